lm80c_ioctl_loader: RTL
=======================

# lm80c_ioctl_loader

Buffered loader between the HPS `ioctl` download stream and the on-chip ROM/RAM write arbiter of the LM80C core. It maps the boot ROM, ROM and PRG file indices onto the 25-bit system address space. It paces writes to the memory-side `clk_ena` through a small FIFO and back-pressures the HPS with `ioctl_wait`. After a PRG load it patches the BASIC end-of-program pointer so the loaded program is immediately listable and runnable.

## Interface
- `BOOT_INDEX`, default 0: ioctl index of the boot ROM image.
- `PRG_INDEX`, default 2: ioctl index of PRG (BASIC program) files.
- `ROM_INDEX`, default 3: ioctl index of the user ROM image.
- `ROM_START_ADDR`, default 25'h00000: base address for BOOT/ROM bytes.
- `PRG_START_ADDR`, default 25'h15608: base address for PRG bytes.
- `PTR_PROGND`, default 25'h155e4: address of the 16-bit little-endian end-of-program pointer.
- `FIFO_DEPTH`, default 4: FIFO entries; power of 2, ≥4.
- `clk`  in  1  system clock (clk_sys domain); single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_download`  in  1  HPS download active.
- `ioctl_index`  in  8  file index, sampled on the rising edge of `ioctl_download`.
- `ioctl_addr`  in  25  byte offset within the file.
- `ioctl_dout`  in  8  byte data.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_wait`  out  1  back-pressure to the HPS.
- `clk_ena`  in  1  memory-side write enable slot.
- `downloading`  out  1  loader busy; CPU held in WAIT by the top level.
- `ROM_done`  out  1  sticky flag: a BOOT or ROM image has completed.
- `wr`  out  1  one-cycle memory write strobe.
- `addr`  out  25  write address.
- `data`  out  8  write data.

## Operation
- States: IDLE, STREAM, DRAIN, PATCH_LO, PATCH_HI.
- IDLE → STREAM on the rising edge of `ioctl_download` when the index is BOOT, ROM or PRG.
  - The index is latched, the byte count is cleared and `downloading` is set.
  - Any other index: the whole download is ignored, state stays IDLE and no writes occur.
- STREAM: each `ioctl_wr` pushes {base + `ioctl_addr`, `ioctl_dout`}.
  - base is `ROM_START_ADDR` for BOOT/ROM and `PRG_START_ADDR` for PRG.
  - The PRG byte count tracks max(`ioctl_addr`)+1.
- STREAM → DRAIN on the falling edge of `ioctl_download`.
- DRAIN: when the FIFO is empty, go to PATCH_LO if the latched index is PRG and the count is ≠0. Otherwise go to IDLE; BOOT/ROM additionally sets `ROM_done`.
- PATCH_LO: on `clk_ena`, write `end[7:0]` to `PTR_PROGND`, then go to PATCH_HI.
- PATCH_HI: on `clk_ena`, write `end[15:8]` to `PTR_PROGND+1`, then go to IDLE.
  - `end` = (`PRG_START_ADDR` + count)[15:0], i.e. the CPU-visible address.
- FIFO pop: any state with the FIFO non-empty and `clk_ena`=1 pops one entry. The registered outputs `wr`=1, `addr`, `data` are valid for exactly one cycle.
- Patch writes are issued only with the FIFO empty, so they never coincide with a pop.
- `ioctl_wait` = (FIFO occupancy ≥ `FIFO_DEPTH`-1).
- A push into a full FIFO is discarded; the HPS honouring `ioctl_wait` prevents this.
- Simultaneous push and pop in one cycle: both occur and occupancy is unchanged.
- A rising `ioctl_download` while not IDLE is ignored.
- `downloading` = (state ≠ IDLE).
- Reset values: `ioctl_wait`=0, `downloading`=0, `ROM_done`=0, `wr`=0, `addr`=0, `data`=0, state IDLE, FIFO empty, count 0.
- Reset mid-operation aborts immediately; the FIFO contents are lost and no patch is issued.

## Timing
- Push is registered on the cycle after `ioctl_wr`.
- Minimum latency from `ioctl_wr` to `wr` is 2 cycles, with `clk_ena` high.
- Throughput is one write per `clk_ena` cycle.
- `ioctl_wait` updates 1 cycle after the occupancy change.
- `ROM_done` rises in the cycle DRAIN → IDLE.
- The last PATCH_HI write and `downloading` falling are in the same cycle.
- Edge detection on `ioctl_download` uses a 1-cycle registered copy.

## Configuration
- `LM80C_LOADER_PTRFIX_EN` defined: PATCH_LO/PATCH_HI are built and PRG loads write the end pointer.
- Not defined: the patch states and count logic are removed. A PRG load goes DRAIN → IDLE with no extra writes; `ROM_done` is unaffected.

## Test plan
- BOOT index 0, 3 bytes AA,BB,CC at offsets 0..2, `clk_ena` always 1 → `wr` at addr 0,1,2 with AA,BB,CC; `ROM_done` rises after the last write; `downloading` falls the same cycle.
- PRG index 2, 16 bytes → writes 25'h15608..25'h15617, then 8'h18 @ 25'h155e4 and 8'h56 @ 25'h155e5; `ROM_done` stays 0.
- `clk_ena` pulsed 1-in-8, bursts of 10 back-to-back `ioctl_wr` → `ioctl_wait` asserts at occupancy 3; no byte is lost; writes are in order.
- Index 5 download of 4 bytes → zero `wr` pulses; `downloading` stays 0.
- `reset_n` pulled low mid-PRG after 5 of 10 bytes → all outputs 0 next cycle, no patch write; a subsequent BOOT load works normally.
- Macro undefined, PRG of 16 bytes → exactly 16 writes and no pointer writes.

Source files
------------

// File: rtl/lm80c_ioctl_loader.sv
// rtl/lm80c_ioctl_loader.sv - HPS ioctl download to LM80C memory writer with pacing FIFO
// Define LM80C_LOADER_PTRFIX_EN to patch the BASIC end-of-program pointer after PRG loads.
module lm80c_ioctl_loader #(
    parameter logic [7:0]  BOOT_INDEX     = 8'd0,
    parameter logic [7:0]  PRG_INDEX      = 8'd2,
    parameter logic [7:0]  ROM_INDEX      = 8'd3,
    parameter logic [24:0] ROM_START_ADDR = 25'h00000,
    parameter logic [24:0] PRG_START_ADDR = 25'h15608,
    parameter logic [24:0] PTR_PROGND     = 25'h155e4,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    input  logic        clk_ena,
    output logic        downloading,
    output logic        ROM_done,
    output logic        wr,
    output logic [24:0] addr,
    output logic [7:0]  data
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] OCC_WAIT = (AW+1)'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_PATCH_LO, S_PATCH_HI} state_t;
    state_t state_q, state_d;

    logic          dl_q, dl_rise, dl_fall, idx_ok, start, rom_done_set;
    logic [7:0]    index_q;
    logic [24:0]   fifo_addr_q [FIFO_DEPTH];
    logic [7:0]    fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   occ_q, occ_d;
    logic          push, pop, wait_q, rom_done_q, wr_q;
    logic [24:0]   addr_q, base;
    logic [7:0]    data_q;
    logic          patch_wr;
    logic [24:0]   patch_addr;
    logic [7:0]    patch_data;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;
    assign idx_ok  = (ioctl_index == BOOT_INDEX) || (ioctl_index == PRG_INDEX) ||
                     (ioctl_index == ROM_INDEX);
    assign base    = (index_q == PRG_INDEX) ? PRG_START_ADDR : ROM_START_ADDR;
    assign push    = (state_q == S_STREAM) && ioctl_wr && (occ_q != OCC_FULL);
    assign pop     = (occ_q != '0) && clk_ena;

`ifdef LM80C_LOADER_PTRFIX_EN
    logic [24:0] count_q, end_w;
    assign end_w = PRG_START_ADDR + count_q;

    // Byte count is the highest offset seen plus one, so out-of-order writes still size correctly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else if (start)
            count_q <= '0;
        else if ((state_q == S_STREAM) && ioctl_wr && ((ioctl_addr + 25'd1) > count_q))
            count_q <= ioctl_addr + 25'd1;
    end
`else
    logic unused_ptr_progend;
    assign unused_ptr_progend = ^PTR_PROGND;
`endif

    always_comb begin
        occ_d = occ_q;
        if (push && !pop)
            occ_d = occ_q + 1'b1;
        else if (pop && !push)
            occ_d = occ_q - 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        start        = 1'b0;
        rom_done_set = 1'b0;
        patch_wr     = 1'b0;
        patch_addr   = '0;
        patch_data   = '0;
        case (state_q)
            S_IDLE: begin
                if (dl_rise && idx_ok) begin
                    start   = 1'b1;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (dl_fall)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (occ_q == '0) begin
`ifdef LM80C_LOADER_PTRFIX_EN
                    if ((index_q == PRG_INDEX) && (count_q != '0))
                        state_d = S_PATCH_LO;
                    else
`endif
                    begin
                        state_d      = S_IDLE;
                        rom_done_set = (index_q != PRG_INDEX);
                    end
                end
            end
`ifdef LM80C_LOADER_PTRFIX_EN
            S_PATCH_LO: begin
                if (clk_ena) begin
                    patch_wr   = 1'b1;
                    patch_addr = PTR_PROGND;
                    patch_data = end_w[7:0];
                    state_d    = S_PATCH_HI;
                end
            end
            S_PATCH_HI: begin
                if (clk_ena) begin
                    patch_wr   = 1'b1;
                    patch_addr = PTR_PROGND + 25'd1;
                    patch_data = end_w[15:8];
                    state_d    = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dl_q       <= 1'b0;
            index_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            wait_q     <= 1'b0;
            rom_done_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            dl_q    <= ioctl_download;
            occ_q   <= occ_d;
            wait_q  <= (occ_d >= OCC_WAIT);
            wr_q    <= 1'b0;
            if (start)
                index_q <= ioctl_index;
            if (rom_done_set)
                rom_done_q <= 1'b1;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                wr_q     <= 1'b1;
                addr_q   <= fifo_addr_q[rd_ptr_q];
                data_q   <= fifo_data_q[rd_ptr_q];
            end else if (patch_wr) begin
                wr_q   <= 1'b1;
                addr_q <= patch_addr;
                data_q <= patch_data;
            end
        end
    end

    // Storage is not reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= base + ioctl_addr;
            fifo_data_q[wr_ptr_q] <= ioctl_dout;
        end
    end

    assign ioctl_wait  = wait_q;
    assign downloading = (state_q != S_IDLE);
    assign ROM_done    = rom_done_q;
    assign wr          = wr_q;
    assign addr        = addr_q;
    assign data        = data_q;
endmodule
